// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer: runs one OUT or IN transaction per start,
// driving the packet encoder and reacting to decoder results with timeout/retry/STALL handling.
module usb_txn_ctrl #(
  parameter logic [7:0] TIMEOUT   = 8'd200,
  parameter logic [3:0] MAX_TRIES = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_in,
  input  logic [6:0]  addr,
  input  logic [3:0]  endp,
  input  logic [63:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [3:0]  tries,
  output logic [63:0] rd_data,
  output logic        enc_start,
  output logic [1:0]  enc_kind,
  output logic [3:0]  enc_pid,
  output logic [63:0] enc_payload,
  input  logic        enc_ready,
  input  logic        enc_done,
  input  logic        dec_avail,
  input  logic        dec_valid,
  input  logic [3:0]  dec_pid,
  input  logic [63:0] dec_data
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [1:0] KIND_TOKEN = 2'd0;
  localparam logic [1:0] KIND_DATA  = 2'd1;
  localparam logic [1:0] KIND_HS    = 2'd2;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_FAIL  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN, S_DATA, S_WAIT_HS, S_WAIT_DATA, S_SEND_HS, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic        is_in_q, is_in_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  endp_q, endp_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  status_q, status_d;
  logic [3:0]  tries_q, tries_d;
  logic [63:0] rd_data_q, rd_data_d;
  logic        enc_start_q, enc_start_d;
  logic [1:0]  enc_kind_q, enc_kind_d;
  logic [3:0]  enc_pid_q, enc_pid_d;
  logic [63:0] enc_payload_q, enc_payload_d;
  logic        retry;
  logic        timed_out;

  function automatic logic [63:0] token_payload(input logic [6:0] a, input logic [3:0] e);
    return {53'd0, a, e};
  endfunction

  // A decoder event in the same cycle as the timer reaching TIMEOUT takes precedence.
  assign timed_out = (timer_q == TIMEOUT) && !dec_avail;

  always_comb begin
    state_d       = state_q;
    timer_d       = 8'd0;
    is_in_d       = is_in_q;
    addr_d        = addr_q;
    endp_d        = endp_q;
    wr_data_d     = wr_data_q;
    status_d      = status_q;
    tries_d       = tries_q;
    rd_data_d     = rd_data_q;
    enc_start_d   = enc_start_q;
    enc_kind_d    = enc_kind_q;
    enc_pid_d     = enc_pid_q;
    enc_payload_d = enc_payload_q;
    retry         = 1'b0;

    if (state_q == S_WAIT_HS || state_q == S_WAIT_DATA) timer_d = timer_q + 8'd1;
    if (enc_start_q && enc_ready) enc_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_in_d       = is_in;
          addr_d        = addr;
          endp_d        = endp;
          wr_data_d     = wr_data;
          tries_d       = 4'd1;
          state_d       = S_TOKEN;
          enc_start_d   = 1'b1;
          enc_kind_d    = KIND_TOKEN;
          enc_pid_d     = is_in ? PID_IN : PID_OUT;
          enc_payload_d = token_payload(addr, endp);
        end
      end
      S_TOKEN: begin
        if (enc_done) begin
          if (is_in_q) begin
            state_d = S_WAIT_DATA;
          end else begin
            state_d       = S_DATA;
            enc_start_d   = 1'b1;
            enc_kind_d    = KIND_DATA;
            enc_pid_d     = PID_DATA0;
            enc_payload_d = wr_data_q;
          end
        end
      end
      S_DATA: begin
        if (enc_done) state_d = S_WAIT_HS;
      end
      S_WAIT_HS: begin
        if (dec_avail) begin
          if (dec_valid && dec_pid == PID_ACK) begin
            state_d  = S_FIN;
            status_d = ST_OK;
          end else if (dec_valid && dec_pid == PID_STALL) begin
            state_d  = S_FIN;
            status_d = ST_STALL;
          end else begin
            retry = 1'b1;
          end
        end else if (timed_out) begin
          retry = 1'b1;
        end
      end
      S_WAIT_DATA: begin
        if (dec_avail) begin
          if (!dec_valid || dec_pid == PID_DATA0) begin
            // Corrupt packets are NAKed; good DATA0 is ACKed.
            state_d       = S_SEND_HS;
            enc_start_d   = 1'b1;
            enc_kind_d    = KIND_HS;
            enc_pid_d     = dec_valid ? PID_ACK : PID_NAK;
            enc_payload_d = 64'd0;
            if (dec_valid) rd_data_d = dec_data;
          end else if (dec_pid == PID_STALL) begin
            state_d  = S_FIN;
            status_d = ST_STALL;
          end else begin
            retry = 1'b1;
          end
        end else if (timed_out) begin
          retry = 1'b1;
        end
      end
      S_SEND_HS: begin
        if (enc_done) begin
          if (enc_pid_q == PID_ACK) begin
            state_d  = S_FIN;
            status_d = ST_OK;
          end else begin
            retry = 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (retry) begin
      if (tries_q == MAX_TRIES) begin
        state_d  = S_FIN;
        status_d = ST_FAIL;
      end else begin
        tries_d       = tries_q + 4'd1;
        state_d       = S_TOKEN;
        enc_start_d   = 1'b1;
        enc_kind_d    = KIND_TOKEN;
        enc_pid_d     = is_in_q ? PID_IN : PID_OUT;
        enc_payload_d = token_payload(addr_q, endp_q);
      end
    end

    done_d = (state_d == S_FIN);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= 8'd0;
      is_in_q       <= 1'b0;
      addr_q        <= 7'd0;
      endp_q        <= 4'd0;
      wr_data_q     <= 64'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      status_q      <= 2'd0;
      tries_q       <= 4'd0;
      rd_data_q     <= 64'd0;
      enc_start_q   <= 1'b0;
      enc_kind_q    <= 2'd0;
      enc_pid_q     <= 4'd0;
      enc_payload_q <= 64'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      is_in_q       <= is_in_d;
      addr_q        <= addr_d;
      endp_q        <= endp_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      status_q      <= status_d;
      tries_q       <= tries_d;
      rd_data_q     <= rd_data_d;
      enc_start_q   <= enc_start_d;
      enc_kind_q    <= enc_kind_d;
      enc_pid_q     <= enc_pid_d;
      enc_payload_q <= enc_payload_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign tries       = tries_q;
  assign rd_data     = rd_data_q;
  assign enc_start   = enc_start_q;
  assign enc_kind    = enc_kind_q;
  assign enc_pid     = enc_pid_q;
  assign enc_payload = enc_payload_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Scoreboard bench for usb_txn_ctrl: stimulus queues expected encoder packets and
// completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_usb_txn_ctrl;

  localparam logic [7:0] TIMEOUT = 8'd200;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_in;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [3:0]  tries;
  logic [63:0] rd_data;
  logic        enc_start;
  logic [1:0]  enc_kind;
  logic [3:0]  enc_pid;
  logic [63:0] enc_payload;
  logic        enc_ready;
  logic        enc_done;
  logic        dec_avail;
  logic        dec_valid;
  logic [3:0]  dec_pid;
  logic [63:0] dec_data;

  logic        enc_hold;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_done;
    logic [1:0]  kind;
    logic [3:0]  pid;
    logic [63:0] payload;
    logic [1:0]  status;
    logic [3:0]  tries;
    logic [63:0] rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  usb_txn_ctrl #(.TIMEOUT(TIMEOUT), .MAX_TRIES(4'd8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_in(is_in), .addr(addr), .endp(endp),
    .wr_data(wr_data), .busy(busy), .done(done), .status(status), .tries(tries),
    .rd_data(rd_data), .enc_start(enc_start), .enc_kind(enc_kind), .enc_pid(enc_pid),
    .enc_payload(enc_payload), .enc_ready(enc_ready), .enc_done(enc_done),
    .dec_avail(dec_avail), .dec_valid(dec_valid), .dec_pid(dec_pid), .dec_data(dec_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_pkt(input logic [1:0] k, input logic [3:0] p, input logic [63:0] pl);
    exp_t e;
    e.is_done = 1'b0; e.kind = k; e.pid = p; e.payload = pl;
    e.status = 2'd0; e.tries = 4'd0; e.rd = 64'd0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done(input logic [1:0] s, input logic [3:0] t, input logic [63:0] r);
    exp_t e;
    e.is_done = 1'b1; e.kind = 2'd0; e.pid = 4'd0; e.payload = 64'd0;
    e.status = s; e.tries = t; e.rd = r;
    exp_q.push_back(e);
  endfunction

  // Encoder model: accepts on enc_start & enc_ready, pulses enc_done 3 cycles later.
  initial begin
    enc_ready = 1'b1;
    enc_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (!enc_hold && !enc_ready) enc_ready = 1'b1;
      if (enc_start && enc_ready && !rst) begin
        @(posedge clk); #1 enc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 enc_done = 1'b1;
        @(posedge clk); #1 enc_done = 1'b0;
        enc_ready = !enc_hold;
      end
    end
  end

  // Monitor: every accepted packet and every done pulse consumes one expected entry.
  always @(negedge clk) begin
    if (!rst && enc_start && enc_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pkt_pid", {60'd0, enc_pid}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pkt_order", {63'd0, mon_e.is_done}, 64'd0);
        chk("pkt_kind", {62'd0, enc_kind}, {62'd0, mon_e.kind});
        chk("pkt_pid", {60'd0, enc_pid}, {60'd0, mon_e.pid});
        chk("pkt_payload", enc_payload, mon_e.payload);
      end
    end
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done_status", {62'd0, status}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_order", {63'd0, mon_e.is_done}, 64'd1);
        chk("done_status", {62'd0, status}, {62'd0, mon_e.status});
        chk("done_tries", {60'd0, tries}, {60'd0, mon_e.tries});
        chk("done_rd_data", rd_data, mon_e.rd);
      end
    end
  end

  task automatic do_start(input logic in, input logic [6:0] a, input logic [3:0] e, input logic [63:0] d);
    start = 1'b1; is_in = in; addr = a; endp = e; wr_data = d;
    @(negedge clk);
    start = 1'b0; addr = 7'h00; endp = 4'h0; wr_data = 64'd0;
    chk("start_busy", {63'd0, busy}, 64'd1);
    chk("start_enc_start", {63'd0, enc_start}, 64'd1);
  endtask

  task automatic wait_enc_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!enc_done && n < 60);
    if (!enc_done) chk("enc_done_wait", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic send_resp(input logic v, input logic [3:0] p, input logic [63:0] d);
    @(negedge clk);
    dec_avail = 1'b1; dec_valid = v; dec_pid = p; dec_data = d;
    @(negedge clk);
    dec_avail = 1'b0; dec_valid = 1'b0; dec_pid = 4'h0; dec_data = 64'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_status"}, {62'd0, status}, 64'd0);
    chk({tag, "_tries"}, {60'd0, tries}, 64'd0);
    chk({tag, "_rd_data"}, rd_data, 64'd0);
    chk({tag, "_enc_start"}, {63'd0, enc_start}, 64'd0);
    chk({tag, "_enc_kind"}, {62'd0, enc_kind}, 64'd0);
    chk({tag, "_enc_pid"}, {60'd0, enc_pid}, 64'd0);
    chk({tag, "_enc_payload"}, enc_payload, 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; is_in = 1'b0; addr = 7'h00; endp = 4'h0; wr_data = 64'd0;
    dec_avail = 1'b0; dec_valid = 1'b0; dec_pid = 4'h0; dec_data = 64'd0;
    enc_hold = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // OUT success
    push_pkt(2'd0, PID_OUT, 64'h051);
    push_pkt(2'd1, PID_DATA0, 64'hDEADBEEF_01234567);
    push_done(2'd0, 4'd1, 64'd0);
    do_start(1'b0, 7'h05, 4'h1, 64'hDEADBEEF_01234567);
    wait_enc_done();
    wait_enc_done();
    send_resp(1'b1, PID_ACK, 64'd0);
    chk("out_ok_done_next_cycle", {63'd0, done}, 64'd1);
    chk("out_ok_busy_in_fin", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("out_ok_busy_after", {63'd0, busy}, 64'd0);

    // IN success
    push_pkt(2'd0, PID_IN, 64'h123);
    push_pkt(2'd2, PID_ACK, 64'd0);
    push_done(2'd0, 4'd1, 64'h0F0F);
    do_start(1'b1, 7'h12, 4'h3, 64'd0);
    wait_enc_done();
    send_resp(1'b1, PID_DATA0, 64'h0F0F);
    chk("in_ok_hs_start", {63'd0, enc_start}, 64'd1);
    wait_enc_done();
    wait_done();
    @(negedge clk);

    // IN with bad CRC, then good data
    push_pkt(2'd0, PID_IN, 64'h123);
    push_pkt(2'd2, PID_NAK, 64'd0);
    push_pkt(2'd0, PID_IN, 64'h123);
    push_pkt(2'd2, PID_ACK, 64'd0);
    push_done(2'd0, 4'd2, 64'hAAAA5555_CAFEF00D);
    do_start(1'b1, 7'h12, 4'h3, 64'd0);
    wait_enc_done();
    send_resp(1'b0, PID_DATA0, 64'h0BAD);
    chk("crc_nak_rd_held", rd_data, 64'h0F0F);
    wait_enc_done();
    wait_enc_done();
    send_resp(1'b1, PID_DATA0, 64'hAAAA5555_CAFEF00D);
    wait_enc_done();
    wait_done();
    @(negedge clk);

    // OUT always NAK: eight attempts then failure
    for (int i = 0; i < 8; i++) begin
      push_pkt(2'd0, PID_OUT, 64'h2A5);
      push_pkt(2'd1, PID_DATA0, 64'h01234567_89ABCDEF);
    end
    push_done(2'd1, 4'd8, 64'hAAAA5555_CAFEF00D);
    do_start(1'b0, 7'h2A, 4'h5, 64'h01234567_89ABCDEF);
    for (int i = 0; i < 8; i++) begin
      wait_enc_done();
      wait_enc_done();
      send_resp(1'b1, PID_NAK, 64'd0);
    end
    chk("nak_fail_done", {63'd0, done}, 64'd1);
    repeat (10) @(negedge clk);
    chk("nak_no_ninth_token", {63'd0, enc_start}, 64'd0);

    // Timeout, then a response exactly at timer == TIMEOUT
    push_pkt(2'd0, PID_IN, 64'h010);
    push_pkt(2'd0, PID_IN, 64'h010);
    push_pkt(2'd2, PID_ACK, 64'd0);
    push_done(2'd0, 4'd2, 64'h1234);
    do_start(1'b1, 7'h01, 4'h0, 64'd0);
    wait_enc_done();
    @(negedge clk);
    n = 0;
    while (!enc_start && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_gap", 64'(n), 64'(TIMEOUT) + 64'd1);
    wait_enc_done();
    @(negedge clk);
    repeat (200) @(negedge clk);
    dec_avail = 1'b1; dec_valid = 1'b1; dec_pid = PID_DATA0; dec_data = 64'h1234;
    @(negedge clk);
    dec_avail = 1'b0; dec_valid = 1'b0; dec_pid = 4'h0; dec_data = 64'd0;
    chk("edge_resp_enc_pid", {60'd0, enc_pid}, {60'd0, PID_ACK});
    wait_enc_done();
    wait_done();
    @(negedge clk);

    // OUT answered with STALL
    push_pkt(2'd0, PID_OUT, 64'h7FF);
    push_pkt(2'd1, PID_DATA0, 64'h1111);
    push_done(2'd2, 4'd1, 64'h1234);
    do_start(1'b0, 7'h7F, 4'hF, 64'h1111);
    wait_enc_done();
    wait_enc_done();
    send_resp(1'b1, PID_STALL, 64'd0);
    chk("stall_done_next_cycle", {63'd0, done}, 64'd1);
    @(negedge clk);

    // Reset during DATA while the encoder is not ready
    enc_hold = 1'b1;
    push_pkt(2'd0, PID_OUT, 64'h033);
    do_start(1'b0, 7'h03, 4'h3, 64'h5555);
    wait_enc_done();
    @(negedge clk);
    chk("rst_pre_enc_start", {63'd0, enc_start}, 64'd1);
    chk("rst_pre_enc_kind", {62'd0, enc_kind}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 1'b0;
    enc_hold = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_idle_busy", {63'd0, busy}, 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
